wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Two-master Wishbone classic arbiter sharing the single user-area slave port (feeding the address
//  decoder/mux) between the Caravel management core (master 0) and an on-chip sequencer/DMA (master 1).
//  Round-robin grant, bus lock for the whole CYC period, and a watchdog that terminates stalled
//  transfers so a missing slave ack cannot hang either master.
// PARAMETERS
//  TIMEOUT_CYCLES  255           cycles of STB-without-ACK before forced termination; 0 disables watchdog
//  CNT_W           8             watchdog counter width; must hold TIMEOUT_CYCLES
//  TIMEOUT_DATA    32'hDEADBEEF  read data returned to master on a timed-out transfer
// PORTS
//  clk              in   1   system clock (single clock domain)
//  rst_n            in   1   asynchronous active-low reset
//  io_wbm0_adr/datwr in  32  master 0 address / write data (same for wbm1)
//  io_wbm0_we/stb/cyc in 1   master 0 control (same for wbm1)
//  io_wbm0_datrd    out  32  master 0 read data (same for wbm1)
//  io_wbm0_ack      out  1   master 0 ack (same for wbm1)
//  io_wbs_adr/datwr out  32  shared slave address / write data
//  io_wbs_we/stb/cyc out 1   shared slave control
//  io_wbs_datrd     in   32  shared slave read data
//  io_wbs_ack       in   1   shared slave ack
//  io_timeout_clr   in   1   synchronous clear of sticky timeout flag
//  io_timeout       out  1   sticky: a watchdog timeout has occurred
//  io_grant         out  2   one-hot current grant (00 = idle), for debug/status
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last_grant=1 (master 0 wins first tie), wdog=0, io_timeout=0.
//   All outputs 0 while in IDLE: slave adr/datwr/we/stb/cyc=0, master ack/datrd=0, io_grant=00.
//  FSM states IDLE, GNT0, GNT1 (registered; grant takes effect the cycle after request is seen).
//   IDLE: cyc0&cyc1 -> GNT of master != last_grant; only cycN -> GNTN; none -> IDLE.
//   GNTn: hold while wbmN_cyc=1 (lock across back-to-back STBs). When wbmN_cyc=0: arbitrate
//    immediately with last_grant=n -> GNT(other) if other cyc=1 (no idle bubble), else IDLE.
//   Entering GNTn sets last_grant=n.
//  Datapath in GNTn (combinational): io_wbs_{adr,datwr,we}=wbmN_*, io_wbs_cyc=wbmN_cyc,
//   io_wbs_stb=wbmN_stb&wbmN_cyc&~to_pulse; wbmN_datrd=io_wbs_datrd, wbmN_ack=io_wbs_ack&wbmN_stb&wbmN_cyc.
//   Non-granted master: ack=0, datrd=0. Slave ack in IDLE or for dropped cyc is discarded.
//  Latency: request cycle N -> slave STB at N+1; slave ack forwarded same cycle (0 added latency).
//  Master drops cyc mid-transfer: slave cyc/stb fall same cycle; state leaves GNTn next edge.
//  Watchdog (TIMEOUT_CYCLES>0): wdog increments each cycle io_wbs_stb=1 & io_wbs_ack=0; clears on
//   ack, stb=0 or grant change. When wdog==TIMEOUT_CYCLES: to_pulse=1 for one cycle: granted master
//   gets ack=1, datrd=TIMEOUT_DATA, slave stb forced 0; wdog->0; io_timeout set next edge.
//   Slave ack arriving in the to_pulse cycle is ignored (master sees exactly one ack).
//  io_timeout: set on to_pulse, cleared by io_timeout_clr; set wins if both in same cycle.
//  io_grant = {state==GNT1, state==GNT0}. No arbitration ever while a granted cyc is high.
// TESTING
//  1 m0 write adr 0x3000_0004 dat 0x12345678, slave acks 2 cycles after stb -> slave stb 1 cycle after
//    req with same adr/dat/we=1; m0 ack coincident with slave ack; m1 ack=0; io_grant 01 then 00.
//  2 after reset m0,m1 assert cyc/stb same cycle -> GNT0 first; m0 drops cyc -> GNT1 next cycle
//    (no IDLE); next simultaneous request -> GNT0 (round-robin).
//  3 m1 holds cyc over 3 back-to-back reads (datrd 0xA5A5_0001..3) while m0 requests -> m0 stalls
//    (ack=0) until m1 cyc=0, m1 receives all 3 data words in order.
//  4 TIMEOUT_CYCLES=4, slave never acks m0 read -> after 4 stall cycles m0 ack=1 one cycle with
//    datrd 0xDEADBEEF, slave stb=0 that cycle, io_timeout=1 until io_timeout_clr pulse.
//  5 rst_n low mid-transfer of m1 -> all outputs 0 immediately (async); after release a tie grants m0.
//  6 m0 drops cyc before ack, slave acks 1 cycle later -> slave cyc low same cycle; ack not forwarded
//    to m0 or m1.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter: round-robin grant, bus locked for the whole CYC period,
// and a watchdog that terminates a stalled transfer with a dummy ack.
module wb_arbiter #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 8,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] io_wbm0_adr,
   input  logic [31:0] io_wbm0_datwr,
   input  logic        io_wbm0_we,
   input  logic        io_wbm0_stb,
   input  logic        io_wbm0_cyc,
   output logic [31:0] io_wbm0_datrd,
   output logic        io_wbm0_ack,
   input  logic [31:0] io_wbm1_adr,
   input  logic [31:0] io_wbm1_datwr,
   input  logic        io_wbm1_we,
   input  logic        io_wbm1_stb,
   input  logic        io_wbm1_cyc,
   output logic [31:0] io_wbm1_datrd,
   output logic        io_wbm1_ack,
   output logic [31:0] io_wbs_adr,
   output logic [31:0] io_wbs_datwr,
   output logic        io_wbs_we,
   output logic        io_wbs_stb,
   output logic        io_wbs_cyc,
   input  logic [31:0] io_wbs_datrd,
   input  logic        io_wbs_ack,
   input  logic        io_timeout_clr,
   output logic        io_timeout,
   output logic [1:0]  io_grant
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t           state, state_nxt;
   logic             last_grant;
   logic [CNT_W-1:0] wdog;
   logic             req_stb;
   logic             to_pulse;

   // A granted master keeps the bus until it drops CYC; on release the other master
   // is picked up on the same edge so there is no idle bubble.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (io_wbm0_cyc && io_wbm1_cyc) state_nxt = last_grant ? GNT0 : GNT1;
            else if (io_wbm0_cyc)           state_nxt = GNT0;
            else if (io_wbm1_cyc)           state_nxt = GNT1;
         end
         GNT0:    if (!io_wbm0_cyc) state_nxt = io_wbm1_cyc ? GNT1 : IDLE;
         GNT1:    if (!io_wbm1_cyc) state_nxt = io_wbm0_cyc ? GNT0 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_stb = 1'b0;
      case (state)
         GNT0:    req_stb = io_wbm0_stb & io_wbm0_cyc;
         GNT1:    req_stb = io_wbm1_stb & io_wbm1_cyc;
         default: req_stb = 1'b0;
      endcase
   end

   assign to_pulse = (TIMEOUT_CYCLES != 0) && req_stb && (wdog == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      io_wbs_adr    = '0;
      io_wbs_datwr  = '0;
      io_wbs_we     = 1'b0;
      io_wbs_cyc    = 1'b0;
      io_wbs_stb    = 1'b0;
      io_wbm0_datrd = '0;
      io_wbm0_ack   = 1'b0;
      io_wbm1_datrd = '0;
      io_wbm1_ack   = 1'b0;
      case (state)
         GNT0: begin
            io_wbs_adr    = io_wbm0_adr;
            io_wbs_datwr  = io_wbm0_datwr;
            io_wbs_we     = io_wbm0_we;
            io_wbs_cyc    = io_wbm0_cyc;
            io_wbs_stb    = req_stb & ~to_pulse;
            io_wbm0_datrd = to_pulse ? TIMEOUT_DATA : io_wbs_datrd;
            io_wbm0_ack   = to_pulse | (io_wbs_ack & req_stb);
         end
         GNT1: begin
            io_wbs_adr    = io_wbm1_adr;
            io_wbs_datwr  = io_wbm1_datwr;
            io_wbs_we     = io_wbm1_we;
            io_wbs_cyc    = io_wbm1_cyc;
            io_wbs_stb    = req_stb & ~to_pulse;
            io_wbm1_datrd = to_pulse ? TIMEOUT_DATA : io_wbs_datrd;
            io_wbm1_ack   = to_pulse | (io_wbs_ack & req_stb);
         end
         default: ;
      endcase
   end

   assign io_grant = {state == GNT1, state == GNT0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wdog       <= '0;
         io_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == GNT0) last_grant <= 1'b0;
         if (state_nxt == GNT1) last_grant <= 1'b1;
         // Counts only genuine stall cycles of the current owner.
         if (TIMEOUT_CYCLES == 0 || state_nxt != state || to_pulse || !req_stb || io_wbs_ack)
            wdog <= '0;
         else
            wdog <= wdog + CNT_W'(1);
         if (to_pulse)            io_timeout <= 1'b1;
         else if (io_timeout_clr) io_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter: one record per clock cycle, plus a
// hand-written asynchronous reset sequence.
module tb_wb_arbiter;

   localparam logic [31:0] A0 = 32'h3000_0004;
   localparam logic [31:0] D0 = 32'h1234_5678;
   localparam logic [31:0] A1 = 32'h3000_1000;
   localparam logic [31:0] D1 = 32'hCAFE_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_adr, m0_datwr, m1_adr, m1_datwr;
   logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
   logic [31:0] m0_datrd, m1_datrd;
   logic        m0_ack, m1_ack;
   logic [31:0] s_adr, s_datwr, s_datrd;
   logic        s_we, s_stb, s_cyc, s_ack;
   logic        timeout_clr, timeout;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        c0, s0, w0, c1, s1, sack;
      logic [31:0] sdat;
      logic        clr;
      logic [1:0]  gnt;
      logic        scyc, sstb, m0ack, m1ack;
      logic [31:0] m0dat, m1dat;
      logic        tout;
   } vec_t;

   vec_t vecs[$];

   wb_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst_n(rst_n),
      .io_wbm0_adr(m0_adr), .io_wbm0_datwr(m0_datwr), .io_wbm0_we(m0_we),
      .io_wbm0_stb(m0_stb), .io_wbm0_cyc(m0_cyc), .io_wbm0_datrd(m0_datrd), .io_wbm0_ack(m0_ack),
      .io_wbm1_adr(m1_adr), .io_wbm1_datwr(m1_datwr), .io_wbm1_we(m1_we),
      .io_wbm1_stb(m1_stb), .io_wbm1_cyc(m1_cyc), .io_wbm1_datrd(m1_datrd), .io_wbm1_ack(m1_ack),
      .io_wbs_adr(s_adr), .io_wbs_datwr(s_datwr), .io_wbs_we(s_we), .io_wbs_stb(s_stb),
      .io_wbs_cyc(s_cyc), .io_wbs_datrd(s_datrd), .io_wbs_ack(s_ack),
      .io_timeout_clr(timeout_clr), .io_timeout(timeout), .io_grant(grant)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic c0, s0, w0, c1, s1, sack, input logic [31:0] sdat,
                               input logic clr, input logic [1:0] gnt, input logic scyc, sstb,
                               m0ack, m1ack, input logic [31:0] m0dat, m1dat, input logic tout);
      vec_t v;
      v.c0 = c0; v.s0 = s0; v.w0 = w0; v.c1 = c1; v.s1 = s1; v.sack = sack;
      v.sdat = sdat; v.clr = clr; v.gnt = gnt; v.scyc = scyc; v.sstb = sstb;
      v.m0ack = m0ack; v.m1ack = m1ack; v.m0dat = m0dat; v.m1dat = m1dat; v.tout = tout;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      m0_cyc = v.c0; m0_stb = v.s0; m0_we = v.w0;
      m1_cyc = v.c1; m1_stb = v.s1;
      s_ack = v.sack; s_datrd = v.sdat; timeout_clr = v.clr;
   endtask

   // Slave-side address/data/we follow whichever master the expected grant names.
   task automatic checkVector(input int idx, input vec_t v);
      logic [31:0] eadr, edat;
      logic        ewe;
      eadr = (v.gnt == 2'b01) ? A0 : (v.gnt == 2'b10) ? A1 : 32'h0;
      edat = (v.gnt == 2'b01) ? D0 : (v.gnt == 2'b10) ? D1 : 32'h0;
      ewe  = (v.gnt == 2'b01) ? v.w0 : 1'b0;
      checkOutput($sformatf("v%0d grant", idx), {30'h0, grant}, {30'h0, v.gnt});
      checkOutput($sformatf("v%0d s_cyc", idx), {31'h0, s_cyc}, {31'h0, v.scyc});
      checkOutput($sformatf("v%0d s_stb", idx), {31'h0, s_stb}, {31'h0, v.sstb});
      checkOutput($sformatf("v%0d s_adr", idx), s_adr, eadr);
      checkOutput($sformatf("v%0d s_datwr", idx), s_datwr, edat);
      checkOutput($sformatf("v%0d s_we", idx), {31'h0, s_we}, {31'h0, ewe});
      checkOutput($sformatf("v%0d m0_ack", idx), {31'h0, m0_ack}, {31'h0, v.m0ack});
      checkOutput($sformatf("v%0d m1_ack", idx), {31'h0, m1_ack}, {31'h0, v.m1ack});
      checkOutput($sformatf("v%0d m0_datrd", idx), m0_datrd, v.m0dat);
      checkOutput($sformatf("v%0d m1_datrd", idx), m1_datrd, v.m1dat);
      checkOutput($sformatf("v%0d timeout", idx), {31'h0, timeout}, {31'h0, v.tout});
   endtask

   initial begin
      m0_adr = A0; m0_datwr = D0; m1_adr = A1; m1_datwr = D1; m1_we = 1'b0;
      applyStimulus(mk(0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0,0,0));
      rst_n = 1'b0;

      // Tie after reset, hand-over without bubble, round-robin on the next tie
      vecs.push_back(mk(1,1,1,1,1,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,1,32'h0,0,          2'b01,1,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,1,0,32'h0,0,          2'b01,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,1,0,32'h0,0,          2'b10,1,1,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,1,1,1,32'h5555_0001,0,  2'b10,1,1,0,1,0,32'h5555_0001,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b10,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,1,32'h0,0,          2'b01,1,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b01,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      // m0 write, slave acks two cycles after stb
      vecs.push_back(mk(1,1,1,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,1,32'h0,0,          2'b01,1,1,1,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b01,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      // m1 locks the bus over three reads while m0 waits
      vecs.push_back(mk(0,0,0,1,1,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,1,32'hA5A5_0001,0,  2'b10,1,1,0,1,0,32'hA5A5_0001,0));
      vecs.push_back(mk(1,1,1,1,1,1,32'hA5A5_0002,0,  2'b10,1,1,0,1,0,32'hA5A5_0002,0));
      vecs.push_back(mk(1,1,1,1,1,0,32'h0,0,          2'b10,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,1,1,1,32'hA5A5_0003,0,  2'b10,1,1,0,1,0,32'hA5A5_0003,0));
      vecs.push_back(mk(1,1,1,0,0,0,32'h0,0,          2'b10,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,1,32'h0000_0077,0,  2'b01,1,1,1,0,32'h0000_0077,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b01,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      // m0 abandons the cycle; late slave acks are dropped
      vecs.push_back(mk(1,1,1,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,1,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,32'h0000_0099,0,  2'b01,0,0,0,0,32'h0000_0099,0,0));
      vecs.push_back(mk(0,0,0,0,0,1,32'h0000_0099,0,  2'b00,0,0,0,0,0,0,0));
      // Watchdog: four stall cycles, forced ack (slave ack in that cycle ignored), sticky flag
      vecs.push_back(mk(1,1,0,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,0,32'h0,0,          2'b01,1,1,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0,1,32'h0000_1111,0,  2'b01,1,0,1,0,32'hDEAD_BEEF,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b01,0,0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,1,          2'b00,0,0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0,32'h0,0,          2'b00,0,0,0,0,0,0,0));

      #12;
      checkVector(-1, mk(0,0,0,0,0,0,0,0, 2'b00,0,0,0,0,0,0,0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkVector(i, vecs[i]);
      end

      // Asynchronous reset in the middle of an m1 transfer
      @(negedge clk);
      applyStimulus(mk(0,0,0,1,1,0,32'h0,0, 2'b00,0,0,0,0,0,0,0));
      @(negedge clk);
      #1;
      checkOutput("rst grant before", {30'h0, grant}, 32'h2);
      s_ack = 1'b1; s_datrd = 32'h0000_1234;
      #1;
      checkOutput("rst m1_ack before", {31'h0, m1_ack}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst grant", {30'h0, grant}, 32'h0);
      checkOutput("rst s_cyc", {31'h0, s_cyc}, 32'h0);
      checkOutput("rst s_stb", {31'h0, s_stb}, 32'h0);
      checkOutput("rst s_adr", s_adr, 32'h0);
      checkOutput("rst m1_ack", {31'h0, m1_ack}, 32'h0);
      checkOutput("rst m1_datrd", m1_datrd, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mk(1,1,1,1,1,0,32'h0,0, 2'b00,0,0,0,0,0,0,0));
      @(negedge clk);
      #1;
      checkOutput("rst tie grant", {30'h0, grant}, 32'h1);
      applyStimulus(mk(0,0,0,0,0,0,32'h0,0, 2'b00,0,0,0,0,0,0,0));
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
